// File: rtl/modn_updown_counter.sv
// Modulo-MOD up/down counter with enable, parallel load, terminal count and wrap pulse.
// Define MODN_CNT_SAT_EN to build the saturating variant (no wrap-around).
module modn_updown_counter #(
    parameter int MOD   = 5,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (MOD < 2 || MOD > 2**WIDTH) begin : g_bad_mod
        $error("modn_updown_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   LIM = (WIDTH+1)'(MOD);

    logic at_max;
    logic at_min;
    logic load_ok;

    assign at_max  = (out == MAX);
    assign at_min  = (out == '0);
    // One extra bit so MOD == 2**WIDTH compares correctly
    assign load_ok = ({1'b0, load_val} < LIM);
    assign tc      = en & (up_dn ? at_max : at_min);

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    out <= load_val;
                end else begin
                    out      <= '0;
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (up_dn) begin
                    if (at_max) begin
`ifdef MODN_CNT_SAT_EN
                        out <= MAX;
`else
                        out  <= '0;
                        wrap <= 1'b1;
`endif
                    end else begin
                        out <= out + WIDTH'(1);
                    end
                end else begin
                    if (at_min) begin
`ifdef MODN_CNT_SAT_EN
                        out <= '0;
`else
                        out  <= MAX;
                        wrap <= 1'b1;
`endif
                    end else begin
                        out <= out - WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Scoreboard bench for modn_updown_counter: MOD=5, MOD=8 (full range) and a cascade.
// Build with +define+MODN_CNT_SAT_EN to check the saturating variant.
module tb_modn_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load;
    logic [2:0] load_val;
    logic [2:0] out, out8;
    logic       tc, wrap, load_err;
    logic       tc8, wrap8, load_err8;

    logic       creset, cen;
    logic [2:0] cout0, cout1;
    logic       ctc0, ctc1, cw0, cw1, cle0, cle1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modn_updown_counter #(.MOD(5), .WIDTH(3)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .out(out), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    modn_updown_counter #(.MOD(8), .WIDTH(3)) dut8 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .out(out8), .tc(tc8), .wrap(wrap8), .load_err(load_err8)
    );

    modn_updown_counter #(.MOD(5), .WIDTH(3)) c0 (
        .clk(clk), .reset(creset), .en(cen), .up_dn(1'b1), .load(1'b0),
        .load_val(3'd0), .out(cout0), .tc(ctc0), .wrap(cw0), .load_err(cle0)
    );

    modn_updown_counter #(.MOD(5), .WIDTH(3)) c1 (
        .clk(clk), .reset(creset), .en(ctc0), .up_dn(1'b1), .load(1'b0),
        .load_val(3'd0), .out(cout1), .tc(ctc1), .wrap(cw1), .load_err(cle1)
    );

    typedef struct {
        int o;
        int w;
        int le;
    } st_t;

    typedef struct {
        st_t a;
        st_t b;
    } pair_t;

    st_t   m5, m8, k0, k1;
    pair_t q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic st_t model(st_t c, int mod, bit r, bit e, bit u, bit l, int lv);
        st_t n;
        n.o  = c.o;
        n.w  = 0;
        n.le = 0;
        if (r) begin
            n.o = 0;
        end else if (l) begin
            if (lv < mod) n.o = lv;
            else begin
                n.o  = 0;
                n.le = 1;
            end
        end else if (e) begin
            if (u) begin
                if (c.o == mod - 1) begin
`ifdef MODN_CNT_SAT_EN
                    n.o = c.o;
`else
                    n.o = 0;
                    n.w = 1;
`endif
                end else n.o = c.o + 1;
            end else begin
                if (c.o == 0) begin
`ifdef MODN_CNT_SAT_EN
                    n.o = 0;
`else
                    n.o = mod - 1;
                    n.w = 1;
`endif
                end else n.o = c.o - 1;
            end
        end
        return n;
    endfunction

    function automatic int tcm(st_t c, int mod, bit e, bit u);
        return (e && (u ? (c.o == mod - 1) : (c.o == 0))) ? 1 : 0;
    endfunction

    task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
        pair_t x;
        reset    = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = 3'(lv);
        #1;
        chk("tc", int'(tc), tcm(m5, 5, e, u));
        chk("tc8", int'(tc8), tcm(m8, 8, e, u));
        m5 = model(m5, 5, r, e, u, l, lv);
        m8 = model(m8, 8, r, e, u, l, lv);
        q.push_back('{m5, m8});
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("out", int'(out), x.a.o);
        chk("wrap", int'(wrap), x.a.w);
        chk("load_err", int'(load_err), x.a.le);
        chk("out8", int'(out8), x.b.o);
        chk("wrap8", int'(wrap8), x.b.w);
        chk("load_err8", int'(load_err8), x.b.le);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 3'd3;
        creset = 1'b1; cen = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_lerr", int'(load_err), 0);
        chk("rst_tc", int'(tc), 0);
        m5 = '{0, 0, 0};
        m8 = '{0, 0, 0};

        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 3);
        step(0, 1, 1, 1, 6);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 5);
        step(0, 0, 1, 1, 7);
        step(0, 0, 1, 1, 4);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 4);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 7);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 5) == 0),
                 $urandom_range(0, 7));
        end

        reset = 1'b1; en = 1'b0; load = 1'b0;
        creset = 1'b0; cen = 1'b1;
        k0 = '{0, 0, 0};
        k1 = '{0, 0, 0};
        @(posedge clk);
        #1;
        creset = 1'b1;
        @(posedge clk);
        #1;
        creset = 1'b0;
        chk("casc_rst0", int'(cout0), 0);
        chk("casc_rst1", int'(cout1), 0);
        for (int i = 1; i <= 30; i++) begin
            int t0;
            t0 = tcm(k0, 5, 1, 1);
            chk("casc_tc0", int'(ctc0), t0);
            k1 = model(k1, 5, 0, t0 != 0, 1, 0, 0);
            k0 = model(k0, 5, 0, 1, 1, 0, 0);
            @(posedge clk);
            #1;
            chk("casc_out0", int'(cout0), k0.o);
            chk("casc_out1", int'(cout1), k1.o);
`ifndef MODN_CNT_SAT_EN
            if (i == 5 || i == 25) begin
                chk("casc_fix0", int'(cout0), 0);
                chk("casc_fix1", int'(cout1), (i == 5) ? 1 : 0);
            end
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
